// File: rtl/div_issue_ctrl_pkg.sv
// Shared EXE-stage definitions for the multicycle divide issue controller:
// FSM state encoding, op codes and default constants.
package div_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4
  } div_state_e;

  localparam logic OP_DIVQ = 1'b0;
  localparam logic OP_DIVR = 1'b1;

  // Held wider than any expected datapath so it can be truncated to DATA_W.
  localparam int DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV0_QUOT = '1;

  localparam int DIV_TIMEOUT = 64;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Pipeline/divide-unit handshake bundle for div_issue_ctrl.
// master = pipeline + divide unit side, slave = the issue controller.
interface div_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);

  logic              req_valid;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [RD_W-1:0]   req_rd;
  logic              req_ready;
  logic              flush;
  logic              stall;

  logic              unit_start;
  logic              unit_op;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              unit_valid;
  logic [DATA_W-1:0] unit_result;

  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush, unit_valid, unit_result,
    input  req_ready, stall, unit_start, unit_op, unit_a, unit_b,
           wb_valid, wb_rd, wb_data, wb_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush, unit_valid, unit_result,
    output req_ready, stall, unit_start, unit_op, unit_a, unit_b,
           wb_valid, wb_rd, wb_data, wb_err
  );

endinterface

// File: rtl/div_issue_ctrl_timer.sv
// Saturating wait counter for multicycle units. expired is high in the
// cycle whose increment reaches TIMEOUT, and stays high once saturated.
module mc_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = !clear && ((count_q == CNT_MAX) || (enable && (count_q == CNT_LAST)));

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the multicycle divide unit: latches one request,
// starts the unit, stalls until result/timeout/flush, then strobes writeback.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input logic          clk,
  input logic          rst_n,
  div_issue_ctrl_if.slave bus
);

  localparam logic [DATA_W-1:0] QUOT_DIV0 = DATA_W'(DIV0_QUOT);

  div_state_e        state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              unit_start_q, unit_start_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_err_q, wb_err_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;
  logic accept;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  assign accept = (state_q == ST_IDLE) && bus.req_valid && !bus.flush;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = bus.req_op;
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          rd_d = bus.req_rd;
          if (bus.req_b == '0) begin
            // Divide-by-zero never reaches the unit; result is resolved here.
            state_d  = ST_WB;
            wb_rd_d  = bus.req_rd;
            wb_err_d = 1'b0;
            case (bus.req_op)
              OP_DIVQ: wb_data_d = QUOT_DIV0;
              OP_DIVR: wb_data_d = bus.req_a;
            endcase
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        timer_clear = 1'b1;
        if (bus.flush) begin
          state_d = bus.unit_valid ? ST_IDLE : ST_DRAIN;
        end else if (bus.unit_valid) begin
          state_d   = ST_WB;
          wb_rd_d   = rd_q;
          wb_data_d = bus.unit_result;
          wb_err_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_en = 1'b1;
        if (bus.flush) begin
          // A result or timeout coinciding with flush already ends the op.
          state_d = (bus.unit_valid || timer_expired) ? ST_IDLE : ST_DRAIN;
        end else if (bus.unit_valid) begin
          state_d   = ST_WB;
          wb_rd_d   = rd_q;
          wb_data_d = bus.unit_result;
          wb_err_d  = 1'b0;
        end else if (timer_expired) begin
          state_d   = ST_WB;
          wb_rd_d   = rd_q;
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end
      end

      ST_DRAIN: begin
        timer_en = 1'b1;
        if (bus.unit_valid || timer_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    unit_start_d = (state_d == ST_ISSUE);
    wb_valid_d   = (state_d == ST_WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
      unit_start_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rd_q         <= rd_d;
      unit_start_q <= unit_start_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.stall      = accept || (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                          (state_q == ST_DRAIN);
  assign bus.unit_start = unit_start_q;
  assign bus.unit_op    = op_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  // Flush during writeback cancels the strobe in that same cycle.
  assign bus.wb_valid   = wb_valid_q && !bus.flush;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_err     = wb_err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl; cycle 0 is the accept cycle
// of each request, inputs change and outputs are sampled mid-cycle.
module tb_div_issue_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  div_issue_ctrl_if #(.DATA_W(32), .RD_W(5)) bus ();

  div_issue_ctrl #(.DATA_W(32), .RD_W(5), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations of one request, filled in by run_op.
  int          wb_cyc, wb_cnt, st_cnt, st_cyc, stall_low, rdy_cyc;
  logic [31:0] wb_d;
  logic [4:0]  wb_r;
  logic        wb_e;
  logic        opnd_ok;

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_op      = 1'b0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_rd      = '0;
    bus.flush       = 1'b0;
    bus.unit_valid  = 1'b0;
    bus.unit_result = '0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [4:0] rd, input int valid_cyc, input int flush_cyc,
                        input logic [31:0] unit_res, input int max_cyc);
    wb_cyc = -1; wb_cnt = 0; st_cnt = 0; st_cyc = -1; stall_low = -1; rdy_cyc = -1;
    wb_d = '0; wb_r = '0; wb_e = 1'b0; opnd_ok = 1'b1;
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      bus.req_valid   = (cyc == 0);
      bus.req_op      = (cyc == 0) ? op : 1'b0;
      bus.req_a       = (cyc == 0) ? a : 32'h0;
      bus.req_b       = (cyc == 0) ? b : 32'h0;
      bus.req_rd      = (cyc == 0) ? rd : 5'h0;
      bus.flush       = (cyc == flush_cyc);
      bus.unit_valid  = (cyc == valid_cyc);
      bus.unit_result = (cyc == valid_cyc) ? unit_res : 32'hBAD0_BAD0;
      #1;
      if (bus.unit_start) begin
        st_cnt++;
        if (st_cyc < 0) st_cyc = cyc;
      end
      if (st_cyc >= 0 && (valid_cyc < 0 || cyc <= valid_cyc) && bus.stall &&
          (bus.unit_a !== a || bus.unit_b !== b || bus.unit_op !== op))
        opnd_ok = 1'b0;
      if (bus.wb_valid) begin
        wb_cnt++;
        if (wb_cyc < 0) begin
          wb_cyc = cyc; wb_d = bus.wb_data; wb_r = bus.wb_rd; wb_e = bus.wb_err;
        end
      end
      if (!bus.stall && stall_low < 0) stall_low = cyc;
      if (cyc > 0 && bus.req_ready && rdy_cyc < 0) rdy_cyc = cyc;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", bus.req_ready); end
    vectors++;
    if ({bus.stall, bus.unit_start, bus.wb_valid, bus.wb_err} !== 4'b0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl got %b want 0000", {bus.stall, bus.unit_start, bus.wb_valid, bus.wb_err});
    end
    vectors++;
    if ({bus.unit_a, bus.unit_b, bus.wb_data} !== 96'h0) begin
      miscompares++; $display("[TB] FAIL reset_data got %h want 0", {bus.unit_a, bus.unit_b, bus.wb_data});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_quotient();
    run_op(32'd100, 32'd7, 1'b0, 5'd3, 42, -1, 32'd14, 50);
    vectors++; if (st_cnt !== 1 || st_cyc !== 1) begin miscompares++; $display("[TB] FAIL quot_start got cnt=%0d cyc=%0d want 1/1", st_cnt, st_cyc); end
    vectors++; if (wb_cyc !== 43 || wb_cnt !== 1) begin miscompares++; $display("[TB] FAIL quot_wb_cycle got %0d (cnt %0d) want 43", wb_cyc, wb_cnt); end
    vectors++; if (wb_d !== 32'd14) begin miscompares++; $display("[TB] FAIL quot_data got %0d want 14", wb_d); end
    vectors++; if (wb_r !== 5'd3 || wb_e !== 1'b0) begin miscompares++; $display("[TB] FAIL quot_rd_err got %0d/%b want 3/0", wb_r, wb_e); end
    vectors++; if (stall_low !== 43) begin miscompares++; $display("[TB] FAIL quot_stall first low got %0d want 43", stall_low); end
    vectors++; if (rdy_cyc !== 44) begin miscompares++; $display("[TB] FAIL quot_ready got %0d want 44", rdy_cyc); end
    vectors++; if (opnd_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL quot_operands_stable got %b want 1", opnd_ok); end
  endtask

  task automatic test_remainder();
    run_op(32'd100, 32'd7, 1'b1, 5'd9, 42, -1, 32'd2, 46);
    vectors++; if (wb_cyc !== 43) begin miscompares++; $display("[TB] FAIL rem_wb_cycle got %0d want 43", wb_cyc); end
    vectors++; if (wb_d !== 32'd2 || wb_e !== 1'b0 || wb_r !== 5'd9) begin
      miscompares++; $display("[TB] FAIL rem_result got d=%0d e=%b rd=%0d want 2/0/9", wb_d, wb_e, wb_r);
    end
    vectors++; if (opnd_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rem_unit_op_stable got %b want 1", opnd_ok); end
  endtask

  task automatic test_div_zero();
    run_op(32'hDEAD, 32'h0, 1'b0, 5'd7, -1, -1, 32'h0, 4);
    vectors++; if (wb_cyc !== 1 || wb_d !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL div0_quot got cyc=%0d d=%h want 1/ffffffff", wb_cyc, wb_d); end
    vectors++; if (st_cnt !== 0 || wb_e !== 1'b0 || wb_r !== 5'd7) begin miscompares++; $display("[TB] FAIL div0_quot_side got start=%0d e=%b rd=%0d want 0/0/7", st_cnt, wb_e, wb_r); end
    vectors++; if (stall_low !== 1 || rdy_cyc !== 2) begin miscompares++; $display("[TB] FAIL div0_stall_ready got %0d/%0d want 1/2", stall_low, rdy_cyc); end
    run_op(32'hDEAD, 32'h0, 1'b1, 5'd8, -1, -1, 32'h0, 4);
    vectors++; if (wb_cyc !== 1 || wb_d !== 32'h0000_DEAD || st_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL div0_rem got cyc=%0d d=%h start=%0d want 1/0000dead/0", wb_cyc, wb_d, st_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'h55, 32'h0, 1'b1, 5'd1, -1, -1, 32'h0, 1);
    vectors++; if (wb_cyc !== 1 || wb_d !== 32'h55) begin miscompares++; $display("[TB] FAIL b2b_first got cyc=%0d d=%h want 1/55", wb_cyc, wb_d); end
    run_op(32'h66, 32'h0, 1'b1, 5'd2, -1, -1, 32'h0, 3);
    vectors++; if (wb_cyc !== 1 || wb_d !== 32'h66 || wb_r !== 5'd2) begin
      miscompares++; $display("[TB] FAIL b2b_second got cyc=%0d d=%h rd=%0d want 1/66/2", wb_cyc, wb_d, wb_r);
    end
  endtask

  task automatic test_timeout();
    run_op(32'd50, 32'd5, 1'b0, 5'd4, -1, -1, 32'h0, 70);
    vectors++; if (wb_cyc !== 66 || wb_cnt !== 1) begin miscompares++; $display("[TB] FAIL timeout_cycle got %0d (cnt %0d) want 66", wb_cyc, wb_cnt); end
    vectors++; if (wb_d !== 32'h0 || wb_e !== 1'b1 || wb_r !== 5'd4) begin
      miscompares++; $display("[TB] FAIL timeout_result got d=%h e=%b rd=%0d want 0/1/4", wb_d, wb_e, wb_r);
    end
    vectors++; if (rdy_cyc !== 67) begin miscompares++; $display("[TB] FAIL timeout_ready got %0d want 67", rdy_cyc); end
  endtask

  task automatic test_flush();
    run_op(32'd100, 32'd7, 1'b0, 5'd5, 42, 10, 32'd14, 48);
    vectors++; if (wb_cnt !== 0) begin miscompares++; $display("[TB] FAIL flush_wait_wb got %0d strobes want 0", wb_cnt); end
    vectors++; if (stall_low !== 43 || rdy_cyc !== 43) begin
      miscompares++; $display("[TB] FAIL flush_wait_drain got stall_low=%0d ready=%0d want 43/43", stall_low, rdy_cyc);
    end
    run_op(32'd81, 32'd9, 1'b0, 5'd6, 12, -1, 32'd9, 16);
    vectors++; if (wb_cyc !== 13 || wb_d !== 32'd9 || wb_r !== 5'd6) begin
      miscompares++; $display("[TB] FAIL flush_next got cyc=%0d d=%0d rd=%0d want 13/9/6", wb_cyc, wb_d, wb_r);
    end
    run_op(32'd81, 32'd9, 1'b0, 5'd6, -1, 0, 32'd0, 4);
    vectors++; if (st_cnt !== 0 || wb_cnt !== 0 || stall_low !== 0 || rdy_cyc !== 1) begin
      miscompares++; $display("[TB] FAIL flush_idle got start=%0d wb=%0d stall_low=%0d ready=%0d want 0/0/0/1", st_cnt, wb_cnt, stall_low, rdy_cyc);
    end
    run_op(32'h77, 32'h0, 1'b1, 5'd2, -1, 1, 32'd0, 3);
    vectors++; if (wb_cnt !== 0 || rdy_cyc !== 2) begin
      miscompares++; $display("[TB] FAIL flush_wb got wb=%0d ready=%0d want 0/2", wb_cnt, rdy_cyc);
    end
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc <= 22; cyc++) begin
      @(negedge clk);
      bus.req_valid = (cyc == 0);
      bus.req_a     = (cyc == 0) ? 32'd100 : 32'd0;
      bus.req_b     = (cyc == 0) ? 32'd7 : 32'd0;
      bus.req_rd    = (cyc == 0) ? 5'd3 : 5'd0;
    end
    #1;
    vectors++; if (bus.stall !== 1'b1 || bus.req_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_pre got stall=%b ready=%b want 1/0", bus.stall, bus.req_ready);
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0 || bus.unit_start !== 1'b0 || bus.wb_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_ctrl got ready=%b stall=%b start=%b wb=%b want 1/0/0/0", bus.req_ready, bus.stall, bus.unit_start, bus.wb_valid);
    end
    vectors++; if ({bus.unit_a, bus.unit_b, bus.wb_data, bus.wb_rd} !== 101'h0) begin
      miscompares++; $display("[TB] FAIL midreset_data got a=%h b=%h d=%h want 0", bus.unit_a, bus.unit_b, bus.wb_data);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(32'd100, 32'd7, 1'b1, 5'd11, 5, -1, 32'd2, 8);
    vectors++; if (wb_cyc !== 6 || wb_d !== 32'd2 || wb_r !== 5'd11 || st_cyc !== 1) begin
      miscompares++; $display("[TB] FAIL midreset_next got cyc=%0d d=%0d rd=%0d start=%0d want 6/2/11/1", wb_cyc, wb_d, wb_r, st_cyc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    test_reset();
    test_quotient();
    test_remainder();
    test_div_zero();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
